// File: rtl/segmented_vector_dot.sv
// -----------------------------------------------------------------------------
// segmented_vector_dot
//
// Computes one signed dot product per row. A row starts with a length word on
// the TIMES stream and is followed by ceil(len/LANES) joined A/B beats carrying
// LANES elements each. Products are summed per beat, accumulated per row, and
// the row result is queued in a result FIFO together with an overflow flag.
//
// Handshake rule (all streams): a transfer happens on a rising clk edge where
// tvalid and tready are both 1. A producer holds tdata stable while
// tvalid=1 and tready=0. The A and B streams are joined: both tready outputs
// are asserted together, only in RUN, and only when both tvalids are high.
//
// Ports
//   clk, rstn                 clock, synchronous active-low reset
//   S_AXIS_A_*                A elements, lane i at [i*DW +: DW]
//   S_AXIS_B_*                B elements, same packing as A
//   S_AXIS_TIMES_*            row length in elements (unsigned, 32 bit)
//   M_AXIS_OUT_tdata/tvalid/tready  row result stream
//   M_AXIS_OUT_tuser          overflow seen in this row
//
// The FSM state is held in state_q (IDLE/RUN/DRAIN) for hierarchical probing.
// -----------------------------------------------------------------------------
module segmented_vector_dot #(
    parameter int DW         = 32,
    parameter int LANES      = 2,
    parameter int ACC_W      = 64,
    parameter int FIFO_DEPTH = 16,
    parameter int SAT_EN     = 0
) (
    input  logic                  clk,
    input  logic                  rstn,

    input  logic [LANES*DW-1:0]   S_AXIS_A_tdata,
    input  logic                  S_AXIS_A_tvalid,
    output logic                  S_AXIS_A_tready,

    input  logic [LANES*DW-1:0]   S_AXIS_B_tdata,
    input  logic                  S_AXIS_B_tvalid,
    output logic                  S_AXIS_B_tready,

    input  logic [31:0]           S_AXIS_TIMES_tdata,
    input  logic                  S_AXIS_TIMES_tvalid,
    output logic                  S_AXIS_TIMES_tready,

    output logic [ACC_W-1:0]      M_AXIS_OUT_tdata,
    output logic                  M_AXIS_OUT_tvalid,
    input  logic                  M_AXIS_OUT_tready,
    output logic                  M_AXIS_OUT_tuser
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // ---------------------------------------------------------------- control
    state_t       state_q;
    logic [31:0]  rem_q;        // elements of the row not yet received
    logic         zero_pend_q;  // zero-length row result to be written

    logic         fifo_full;
    logic         fifo_empty;
    logic         times_hs;
    logic         beat_hs;
    logic         last_beat;

    assign S_AXIS_TIMES_tready = rstn && (state_q == ST_IDLE) && !fifo_full && !zero_pend_q;
    assign beat_hs             = rstn && (state_q == ST_RUN) && S_AXIS_A_tvalid && S_AXIS_B_tvalid;
    assign S_AXIS_A_tready     = beat_hs;
    assign S_AXIS_B_tready     = beat_hs;
    assign times_hs            = S_AXIS_TIMES_tvalid && S_AXIS_TIMES_tready;
    // Counting remaining elements down avoids a divide and never wraps,
    // since rem_q only decrements while it exceeds LANES.
    assign last_beat           = (rem_q <= 32'(LANES));

    // -------------------------------------------------------------- pipeline
    logic                    s1_vld_q, s1_last_q;
    logic signed [2*DW-1:0]  s1_prod_q [LANES];
    logic                    s2_vld_q, s2_last_q;
    logic [ACC_W-1:0]        s2_sum_q;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic                    ovf_q, ovf_d;
    logic                    sat_q, sat_d;   // clamped; hold for the rest of the row
    logic                    s3_last_q;      // acc_q now holds the final row sum

    logic signed [2*DW-1:0]  a_ext [LANES];
    logic signed [2*DW-1:0]  b_ext [LANES];
    logic signed [2*DW-1:0]  prod_d [LANES];
    logic [ACC_W-1:0]        lane_sum_d;
    logic [ACC_W-1:0]        acc_sum;
    logic                    add_ovf;

    // Stage 1 operands: lanes beyond the row end contribute zero. On non-last
    // beats rem_q > LANES, so every lane passes the test.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            a_ext[i]  = (2*DW)'($signed(S_AXIS_A_tdata[i*DW +: DW]));
            b_ext[i]  = (2*DW)'($signed(S_AXIS_B_tdata[i*DW +: DW]));
            prod_d[i] = '0;
            if (32'(i) < rem_q) begin
                prod_d[i] = a_ext[i] * b_ext[i];
            end
        end
    end

    always_comb begin
        lane_sum_d = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum_d = lane_sum_d + ACC_W'(s1_prod_q[i]);
        end
    end

    assign acc_sum = acc_q + s2_sum_q;
    assign add_ovf = (acc_q[ACC_W-1] == s2_sum_q[ACC_W-1]) &&
                     (acc_sum[ACC_W-1] != acc_q[ACC_W-1]);

    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        sat_d = sat_q;
        if (times_hs) begin
            acc_d = '0;
            ovf_d = 1'b0;
            sat_d = 1'b0;
        end else if (s2_vld_q && !sat_q) begin
            acc_d = acc_sum;
            if (add_ovf) begin
                ovf_d = 1'b1;
                if (SAT_EN != 0) begin
                    // A positive accumulator can only overflow upward.
                    acc_d = acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX;
                    sat_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
            for (int i = 0; i < LANES; i++) s1_prod_q[i] <= '0;
            s2_vld_q  <= 1'b0;
            s2_last_q <= 1'b0;
            s2_sum_q  <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            sat_q     <= 1'b0;
            s3_last_q <= 1'b0;
        end else begin
            s1_vld_q  <= beat_hs;
            s1_last_q <= beat_hs && last_beat;
            if (beat_hs) begin
                for (int i = 0; i < LANES; i++) s1_prod_q[i] <= prod_d[i];
            end
            s2_vld_q  <= s1_vld_q;
            s2_last_q <= s1_last_q;
            if (s1_vld_q) s2_sum_q <= lane_sum_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            sat_q     <= sat_d;
            s3_last_q <= s2_last_q;
        end
    end

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            zero_pend_q <= 1'b0;
        end else begin
            zero_pend_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (times_hs) begin
                        if (S_AXIS_TIMES_tdata == 32'd0) begin
                            zero_pend_q <= 1'b1;
                        end else begin
                            rem_q   <= S_AXIS_TIMES_tdata;
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (beat_hs) begin
                        if (last_beat) begin
                            rem_q   <= '0;
                            state_q <= ST_DRAIN;
                        end else begin
                            rem_q <= rem_q - 32'(LANES);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (s3_last_q) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // ----------------------------------------------------------- result FIFO
    logic [ACC_W:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push, push_ok, pop, out_vld;
    logic [ACC_W:0]   push_data;

    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push       = s3_last_q || zero_pend_q;
    // TIMES is refused while full and only one row is in flight, so a push
    // never meets a full FIFO; the guard keeps the pointers safe regardless.
    assign push_ok    = push && !fifo_full;
    assign push_data  = zero_pend_q ? '0 : {ovf_q, acc_q};
    assign out_vld    = rstn && !fifo_empty;
    assign pop        = out_vld && M_AXIS_OUT_tready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push_ok && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push_ok) count_q <= count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && push_ok) mem_q[wr_ptr_q] <= push_data;
    end

    assign M_AXIS_OUT_tvalid = out_vld;
    assign M_AXIS_OUT_tdata  = out_vld ? mem_q[rd_ptr_q][ACC_W-1:0] : '0;
    assign M_AXIS_OUT_tuser  = out_vld ? mem_q[rd_ptr_q][ACC_W]     : 1'b0;

endmodule

// File: tb/tb_segmented_vector_dot.sv
// Directed bench for segmented_vector_dot (LANES=2, DW=32, ACC_W=64).
// A wrapping instance and a saturating instance share every input.
module tb_segmented_vector_dot;
    localparam int DW    = 32;
    localparam int LANES = 2;
    localparam int ACC_W = 64;

    logic              clk = 1'b0;
    logic              rstn;
    logic [LANES*DW-1:0] a_data, b_data;
    logic              a_valid, b_valid;
    logic              a_ready, b_ready, s_a_ready, s_b_ready;
    logic [31:0]       t_data;
    logic              t_valid, t_ready, s_t_ready;
    logic [ACC_W-1:0]  o_data, s_o_data;
    logic              o_valid, o_user, s_o_valid, s_o_user;
    logic              o_ready;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    segmented_vector_dot #(.DW(DW), .LANES(LANES), .ACC_W(ACC_W), .FIFO_DEPTH(16), .SAT_EN(0)) u_dut (
        .clk(clk), .rstn(rstn),
        .S_AXIS_A_tdata(a_data), .S_AXIS_A_tvalid(a_valid), .S_AXIS_A_tready(a_ready),
        .S_AXIS_B_tdata(b_data), .S_AXIS_B_tvalid(b_valid), .S_AXIS_B_tready(b_ready),
        .S_AXIS_TIMES_tdata(t_data), .S_AXIS_TIMES_tvalid(t_valid), .S_AXIS_TIMES_tready(t_ready),
        .M_AXIS_OUT_tdata(o_data), .M_AXIS_OUT_tvalid(o_valid), .M_AXIS_OUT_tready(o_ready),
        .M_AXIS_OUT_tuser(o_user)
    );

    segmented_vector_dot #(.DW(DW), .LANES(LANES), .ACC_W(ACC_W), .FIFO_DEPTH(16), .SAT_EN(1)) u_sat (
        .clk(clk), .rstn(rstn),
        .S_AXIS_A_tdata(a_data), .S_AXIS_A_tvalid(a_valid), .S_AXIS_A_tready(s_a_ready),
        .S_AXIS_B_tdata(b_data), .S_AXIS_B_tvalid(b_valid), .S_AXIS_B_tready(s_b_ready),
        .S_AXIS_TIMES_tdata(t_data), .S_AXIS_TIMES_tvalid(t_valid), .S_AXIS_TIMES_tready(s_t_ready),
        .M_AXIS_OUT_tdata(s_o_data), .M_AXIS_OUT_tvalid(s_o_valid), .M_AXIS_OUT_tready(o_ready),
        .M_AXIS_OUT_tuser(s_o_user)
    );

    // ---------------------------------------------------------------- helpers
    task automatic chk(input string tag, input logic [ACC_W+1:0] got, input logic [ACC_W+1:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_times(input logic [31:0] len);
        int n;
        t_data  = len;
        t_valid = 1'b1;
        #1;
        n = 0;
        while (t_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            n_vec++;
            n_err++;
            $error("FAIL times_timeout: observed no TIMES tready expected tready within 200 cycles");
        end
        tick();
        t_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] a0, input logic [31:0] a1,
                             input logic [31:0] b0, input logic [31:0] b1);
        int n;
        a_data  = {a1, a0};
        b_data  = {b1, b0};
        a_valid = 1'b1;
        b_valid = 1'b1;
        #1;
        n = 0;
        while (a_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            n_vec++;
            n_err++;
            $error("FAIL beat_timeout: observed no A/B tready expected tready within 200 cycles");
        end
        tick();
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // --------------------------------------------------------------- stimulus
    initial begin
        rstn    = 1'b0;
        a_data  = '0;
        b_data  = '0;
        a_valid = 1'b1;
        b_valid = 1'b1;
        t_data  = 32'd1;
        t_valid = 1'b1;
        o_ready = 1'b1;
        repeat (3) tick();

        // Reset state
        chk("rst_out",        {o_valid, o_user, o_data}, '0);
        chk("rst_sat_out",    {s_o_valid, s_o_user, s_o_data}, '0);
        chk("rst_times_rdy",  66'(t_ready), 66'd0);
        chk("rst_ab_rdy",     66'({a_ready, b_ready}), 66'd0);

        rstn    = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        t_valid = 1'b0;
        tick();
        chk("idle_times_rdy", 66'(t_ready), 66'd1);

        // Row of 3 elements: last lane masked, 4+10+18 = 32, valid 4 cycles after last beat
        send_times(32'd3);
        send_beat(32'd1, 32'd2, 32'd4, 32'd5);
        send_beat(32'd3, 32'h7FFF_FFFF, 32'd6, 32'h7FFF_FFFF);
        tick();
        tick();
        chk("row3_t3", {o_valid, o_user, o_data}, '0);
        tick();
        chk("row3_t4", {o_valid, o_user, o_data}, {1'b1, 1'b0, 64'd32});
        tick();
        chk("row3_pop", 66'(o_valid), 66'd0);

        // Zero-length row with A/B offered: nothing consumed, result 0 two cycles later
        a_data  = {32'd9, 32'd9};
        b_data  = {32'd9, 32'd9};
        a_valid = 1'b1;
        b_valid = 1'b1;
        send_times(32'd0);
        a_valid = 1'b1;
        b_valid = 1'b1;
        #1;
        chk("zero_no_beat",  66'(a_ready), 66'd0);
        chk("zero_t_block",  66'(t_ready), 66'd0);
        chk("zero_t1",       66'(o_valid), 66'd0);
        tick();
        chk("zero_t2", {o_valid, o_user, o_data}, {1'b1, 1'b0, 64'd0});
        a_valid = 1'b0;
        b_valid = 1'b0;
        tick();

        // Overflow: 4 x (2^31-1)^2
        send_times(32'd4);
        send_beat(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        send_beat(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        repeat (3) tick();
        chk("ovf_wrap", {o_valid, o_user, o_data},     {1'b1, 1'b1, 64'hFFFF_FFFC_0000_0004});
        chk("ovf_sat",  {s_o_valid, s_o_user, s_o_data}, {1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF});
        tick();

        // Negative product; lane 1 is beyond the row and must not count; flags cleared
        send_times(32'd1);
        send_beat(32'hFFFF_FFFD, 32'd100, 32'd7, 32'd100);
        repeat (3) tick();
        chk("neg_wrap", {o_valid, o_user, o_data},       {1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFEB});
        chk("neg_sat",  {s_o_valid, s_o_user, s_o_data}, {1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFEB});
        tick();

        // FIFO full: 16 rows buffered with the sink stalled, 17th row refused
        o_ready = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            send_times(32'd1);
            send_beat(32'(k), 32'd5, 32'(k), 32'd5);
        end
        repeat (6) tick();
        t_data  = 32'd1;
        t_valid = 1'b1;
        #1;
        chk("full_t_block", 66'(t_ready), 66'd0);
        chk("full_head",    {o_valid, o_user, o_data}, {1'b1, 1'b0, 64'd1});
        repeat (3) tick();
        chk("full_t_hold",  66'(t_ready), 66'd0);
        chk("full_stable",  {o_valid, o_user, o_data}, {1'b1, 1'b0, 64'd1});
        t_valid = 1'b0;
        o_ready = 1'b1;
        #1;
        for (int k = 1; k <= 16; k++) begin
            chk("fifo_order", {o_valid, o_user, o_data}, {1'b1, 1'b0, 64'(k * k)});
            tick();
        end
        chk("fifo_drained", 66'(o_valid), 66'd0);
        send_times(32'd1);
        send_beat(32'd17, 32'd5, 32'd17, 32'd5);
        repeat (3) tick();
        chk("row17", {o_valid, o_user, o_data}, {1'b1, 1'b0, 64'd289});
        tick();

        // Reset mid-row: one beat of a 4-element row, then a 1-cycle reset
        send_times(32'd4);
        send_beat(32'd9, 32'd9, 32'd9, 32'd9);
        a_valid = 1'b1;
        b_valid = 1'b1;
        rstn    = 1'b0;
        #1;
        chk("midrst_ab_rdy", 66'({a_ready, b_ready}), 66'd0);
        chk("midrst_t_rdy",  66'(t_ready), 66'd0);
        tick();
        rstn    = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            chk("midrst_no_out", 66'({o_valid, s_o_valid}), 66'd0);
            tick();
        end
        send_times(32'd2);
        send_beat(32'd2, 32'd3, 32'd5, 32'd7);
        repeat (3) tick();
        chk("post_rst",     {o_valid, o_user, o_data},       {1'b1, 1'b0, 64'd31});
        chk("post_rst_sat", {s_o_valid, s_o_user, s_o_data}, {1'b1, 1'b0, 64'd31});
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
